// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller that sits in front of the cpu.
// It synchronises 8 IRQ sources and one NMI source, latches pending bits
// (edge or level per bit), and drives active-low IRQ/NMI lines to the cpu.
// The cpu sees four byte registers at BASE_ADDR: STATUS, MASK, MODE, VECTOR.
module irq_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter int          N_SRC     = 8,
    parameter int          NMI_PULSE = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] add_bus,
    input  logic [7:0]  cpu_dout,
    input  logic        write_en,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    input  logic [7:0]  irq_src,
    input  logic        nmi_src,
    output logic        irq_n,
    output logic        nmi_n
);

    localparam int             CNT_W       = $clog2(NMI_PULSE + 1);
    localparam logic [8:0]     SRC_ONEHOT  = 9'd1 << N_SRC;
    // Bits at or above N_SRC are permanently zero in pending/mask/mode.
    localparam logic [7:0]     SRC_MASK    = SRC_ONEHOT[7:0] - 8'd1;
    localparam logic [CNT_W-1:0] NMI_LOAD  = CNT_W'(NMI_PULSE);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    // Lowest set bit index; scanning downward lets the lowest index win.
    function automatic logic [2:0] lowest_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [7:0]       irq_s1_r, irq_s2_r, irq_s3_r;
    logic             nmi_s1_r, nmi_s2_r, nmi_s3_r;
    logic [7:0]       pending_r, mask_r, mode_r;
    logic [CNT_W-1:0] nmi_cnt_r;
    logic             irq_n_r, nmi_n_r;

    logic [15:0]      offset_s;
    logic             hit_s, wr_s;
    logic [7:0]       irq_rise_s, masked_s, vector_s, pending_nxt_s;
    logic             nmi_rise_s;
    logic [CNT_W-1:0] nmi_cnt_nxt_s;

    // Address decode: the window may sit at any base, so compare the offset.
    always_comb begin
        offset_s = add_bus - BASE_ADDR;
        hit_s    = (offset_s[15:2] == 14'd0);
        wr_s     = hit_s & write_en;
        rd_hit   = hit_s & ~write_en;
    end

    // Edge detection on the synchronised sources and the derived vector.
    always_comb begin
        irq_rise_s = irq_s2_r & ~irq_s3_r;
        nmi_rise_s = nmi_s2_r & ~nmi_s3_r;
        masked_s   = pending_r & mask_r;
        vector_s   = {(|masked_s), 4'd0, lowest_index(masked_s)};
    end

    // Next pending: edge bits set on rise (beating W1C), level bits follow s2.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < 8; i++) begin
            if (mode_r[i]) begin
                if (irq_rise_s[i]) begin
                    pending_nxt_s[i] = 1'b1;
                end else if (wr_s && (offset_s[1:0] == 2'd0) && cpu_dout[i]) begin
                    pending_nxt_s[i] = 1'b0;
                end else begin
                    pending_nxt_s[i] = pending_r[i];
                end
            end else begin
                pending_nxt_s[i] = irq_s2_r[i];
            end
        end
        pending_nxt_s = pending_nxt_s & SRC_MASK;
    end

    // NMI pulse counter: a fresh edge (re)loads, otherwise count down to zero.
    always_comb begin
        if (nmi_rise_s) begin
            nmi_cnt_nxt_s = NMI_LOAD;
        end else if (nmi_cnt_r != CNT_ZERO) begin
            nmi_cnt_nxt_s = nmi_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            nmi_cnt_nxt_s = CNT_ZERO;
        end
    end

    // Register read mux; reads are side-effect free.
    always_comb begin
        case (offset_s[1:0])
            2'd0:    rd_data = pending_r;
            2'd1:    rd_data = mask_r;
            2'd2:    rd_data = mode_r;
            2'd3:    rd_data = vector_s;
            default: rd_data = 8'd0;
        endcase
    end

    // Two-stage synchronisers plus a third stage holding the previous s2.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            irq_s1_r <= 8'd0;
            irq_s2_r <= 8'd0;
            irq_s3_r <= 8'd0;
            nmi_s1_r <= 1'b0;
            nmi_s2_r <= 1'b0;
            nmi_s3_r <= 1'b0;
        end else begin
            irq_s1_r <= irq_src;
            irq_s2_r <= irq_s1_r;
            irq_s3_r <= irq_s2_r;
            nmi_s1_r <= nmi_src;
            nmi_s2_r <= nmi_s1_r;
            nmi_s3_r <= nmi_s2_r;
        end
    end

    // Pending bits.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pending_r <= 8'd0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // MASK and MODE registers; VECTOR writes fall through and are ignored.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            mask_r <= 8'd0;
            mode_r <= SRC_MASK;
        end else if (wr_s && (offset_s[1:0] == 2'd1)) begin
            mask_r <= cpu_dout & SRC_MASK;
            mode_r <= mode_r;
        end else if (wr_s && (offset_s[1:0] == 2'd2)) begin
            mask_r <= mask_r;
            mode_r <= cpu_dout & SRC_MASK;
        end else begin
            mask_r <= mask_r;
            mode_r <= mode_r;
        end
    end

    // NMI counter state.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            nmi_cnt_r <= CNT_ZERO;
        end else begin
            nmi_cnt_r <= nmi_cnt_nxt_s;
        end
    end

    // Registered active-low cpu lines; nmi_n tracks the counter's next value
    // so the line is low for exactly NMI_PULSE cycles after a load.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            irq_n_r <= 1'b1;
            nmi_n_r <= 1'b1;
        end else begin
            irq_n_r <= ~(|(pending_r & mask_r));
            nmi_n_r <= (nmi_cnt_nxt_s == CNT_ZERO);
        end
    end

    assign irq_n = irq_n_r;
    assign nmi_n = nmi_n_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Stimulus pushes expectations into a queue;
// a monitor pops one whenever the DUT presents read data (rd_hit) or the
// stimulus marks an output-pin sample slot.
module tb_irq_ctrl;

    localparam logic [15:0] BASE = 16'hD000;

    logic        clk = 1'b0;
    logic        res;
    logic [15:0] add_bus;
    logic [7:0]  cpu_dout;
    logic        write_en;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic [7:0]  irq_src;
    logic        nmi_src;
    logic        irq_n;
    logic        nmi_n;
    logic        pin_chk;

    typedef struct {
        logic [1:0] kind;   // 0 read data, 1 irq_n, 2 nmi_n
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [7:0] act;

    irq_ctrl #(.BASE_ADDR(BASE), .N_SRC(8), .NMI_PULSE(4)) dut (
        .clk(clk), .res(res), .add_bus(add_bus), .cpu_dout(cpu_dout),
        .write_en(write_en), .rd_data(rd_data), .rd_hit(rd_hit),
        .irq_src(irq_src), .nmi_src(nmi_src), .irq_n(irq_n), .nmi_n(nmi_n)
    );

    always #5 clk = ~clk;

    // Monitor: sample on the falling edge, compare against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_hit || pin_chk) begin
                if (sb_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_output: rd_hit=%0b rd_data=%02h with no expectation queued", rd_hit, rd_data);
                end else begin
                    cur = sb_q.pop_front();
                    n_vec++;
                    case (cur.kind)
                        2'd0:    act = rd_data;
                        2'd1:    act = {7'd0, irq_n};
                        default: act = {7'd0, nmi_n};
                    endcase
                    if (act !== cur.exp) begin
                        n_miss++;
                        $display("FAIL %s: got %02h expected %02h", cur.name, act, cur.exp);
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string name);
        push(2'd0, exp, name);
        add_bus  = BASE + {14'd0, off};
        write_en = 1'b0;
        tick();
        add_bus  = 16'h0000;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] data);
        add_bus  = BASE + {14'd0, off};
        cpu_dout = data;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        add_bus  = 16'h0000;
        cpu_dout = 8'h00;
    endtask

    task automatic chk_pin(input logic [1:0] kind, input logic exp, input string name);
        push(kind, {7'd0, exp}, name);
        pin_chk = 1'b1;
        tick();
        pin_chk = 1'b0;
    endtask

    initial begin
        res = 1'b1; add_bus = 16'h0000; cpu_dout = 8'h00; write_en = 1'b0;
        irq_src = 8'h00; nmi_src = 1'b0; pin_chk = 1'b0;
        tick(); tick();
        res = 1'b0;

        // Reset state
        chk_pin(2'd1, 1'b1, "rst_irq_n");
        chk_pin(2'd2, 1'b1, "rst_nmi_n");
        rd(2'd1, 8'h00, "rst_mask");
        rd(2'd2, 8'hFF, "rst_mode");
        rd(2'd0, 8'h00, "rst_status");
        rd(2'd3, 8'h00, "rst_vector");

        // Edge IRQ on source 0 with three-edge latency
        wr(2'd1, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        chk_pin(2'd1, 1'b1, "edge_lat1");
        chk_pin(2'd1, 1'b1, "edge_lat2");
        chk_pin(2'd1, 1'b1, "edge_lat3");
        chk_pin(2'd1, 1'b0, "edge_irq_low");
        rd(2'd0, 8'h01, "edge_status");
        rd(2'd3, 8'h80, "edge_vector");
        wr(2'd0, 8'h01);
        chk_pin(2'd1, 1'b0, "w1c_irq_still_low");
        chk_pin(2'd1, 1'b1, "w1c_irq_high");

        // Priority between sources 5 and 2
        wr(2'd1, 8'hFF);
        irq_src = 8'h24;
        tick(); tick(); tick();
        rd(2'd3, 8'h82, "prio_vector_2");
        rd(2'd0, 8'h24, "prio_status");
        wr(2'd0, 8'h04);
        rd(2'd3, 8'h85, "prio_vector_5");
        irq_src = 8'h00;
        wr(2'd0, 8'hFF);
        rd(2'd0, 8'h00, "prio_cleared");

        // Level mode on source 3
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h08);
        irq_src = 8'h08;
        tick(); tick(); tick();
        wr(2'd0, 8'h08);
        rd(2'd0, 8'h08, "level_w1c_ignored");
        chk_pin(2'd1, 1'b0, "level_irq_low");
        irq_src = 8'h00;
        tick(); tick();
        rd(2'd0, 8'h08, "level_drop_lat");
        chk_pin(2'd1, 1'b0, "level_irq_lag");
        rd(2'd0, 8'h00, "level_status_clear");
        chk_pin(2'd1, 1'b1, "level_irq_high");
        wr(2'd2, 8'hFF);

        // Set and W1C in the same cycle: set wins
        wr(2'd1, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick();
        wr(2'd0, 8'h01);
        rd(2'd0, 8'h01, "race_set_wins");
        wr(2'd0, 8'h01);
        rd(2'd0, 8'h00, "race_w1c_after");

        // NMI held high: one pulse of exactly 4 cycles
        nmi_src = 1'b1;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            chk_pin(2'd2, (i >= 1 && i <= 4) ? 1'b0 : 1'b1, $sformatf("nmi_single_%0d", i));
        end

        // Second NMI edge mid-pulse reloads the counter
        nmi_src = 1'b0;
        repeat (5) tick();
        nmi_src = 1'b1;
        tick();
        nmi_src = 1'b0;
        tick();
        nmi_src = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk_pin(2'd2, (i >= 1 && i <= 6) ? 1'b0 : 1'b1, $sformatf("nmi_reload_%0d", i));
        end

        // Reset mid-run, mid-pulse
        nmi_src = 1'b0;
        repeat (5) tick();
        wr(2'd1, 8'hFF);
        nmi_src = 1'b1;
        irq_src = 8'h10;
        tick(); tick();
        chk_pin(2'd2, 1'b1, "midrst_nmi_pre");
        chk_pin(2'd2, 1'b0, "midrst_nmi_low");
        chk_pin(2'd1, 1'b0, "midrst_irq_low");
        res = 1'b1;
        chk_pin(2'd2, 1'b1, "midrst_nmi_n");
        chk_pin(2'd1, 1'b1, "midrst_irq_n");
        irq_src = 8'h00;
        nmi_src = 1'b0;
        res = 1'b0;
        rd(2'd1, 8'h00, "midrst_mask");
        rd(2'd2, 8'hFF, "midrst_mode");
        rd(2'd0, 8'h00, "midrst_status");
        chk_pin(2'd1, 1'b1, "post_rst_irq_n");
        chk_pin(2'd2, 1'b1, "post_rst_nmi_n");

        // Drain: every queued expectation must have been consumed.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            tick();
        end
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
